spi_slave_fifo: RTL and testbench
=================================

Name: spi_slave_fifo

Overview:
- Parametrised successor to the 8-bit mode-0 ESP32 SPI slave, for ESP32 <-> FPGA links.
- Adds configurable word width and SPI mode (CPOL/CPHA), plus RX and TX FIFOs with valid/ready handshakes, so the command decoder can queue multi-word responses ahead of the master's clocks.
- Includes error flags and frame markers.
- Sits between the ESP32 SPI pins and the OSD/command logic; all internal logic runs on clk_sys.

Parameters:
- DATA_W, 8: bits per SPI word, MSB first; legal 4..32.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- RX_DEPTH, 4: RX FIFO entries; power of 2, >=2.
- TX_DEPTH, 4: TX FIFO entries; power of 2, >=2.
- SYNC_STAGES, 3: synchroniser depth for spi_clk, spi_cs_n and spi_mosi; >=2.
- IDLE_WORD, 0: word shifted out when the TX FIFO is empty at a load point.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- rst_n  in  1  reset.
- spi_clk  in  1  SPI clock, async to clk_sys, <= clk_sys/5.
- spi_mosi  in  1  master data in.
- spi_cs_n  in  1  chip select, active low.
- spi_miso  out  1  slave data out.
- spi_miso_oe  out  1  MISO output enable; high while CS is active (synchronised).
- rx_data  out  DATA_W  RX FIFO head.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  pop RX head when rx_valid & rx_ready.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full.
- busy  out  1  registered synchronised CS-active.
- frame_start  out  1  one-cycle pulse on CS assert.
- frame_end  out  1  one-cycle pulse on CS deassert.
- rx_overflow  out  1  one-cycle pulse when a received word is dropped.
- tx_underrun  out  1  one-cycle pulse when IDLE_WORD is substituted.
- word_cnt  out  16  words completed in the current frame; saturates at 16'hFFFF.

Behaviour:
- Reset (clock and reset): rst_n is asynchronous, active-low; clock is clk_sys.
- Reset values:
  - All outputs 0.
  - Both FIFOs empty, so tx_ready = 1 once reset is released.
  - CS synchroniser reset to the inactive (1) level.
  - SPI clock synchroniser reset to CPOL.
- Edge detection:
  - Edges are taken from the last two synchroniser stages.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Bit counter:
  - Counts 0..DATA_W-1 and advances on each sample edge.
  - Forced to 0 while CS is inactive.
  - word_done is asserted on the sample edge with count = DATA_W-1.
- RX path:
  - The shifter captures the synchronised MOSI on each sample edge.
  - On word_done the full word {shift[DATA_W-2:0], mosi} is pushed into the RX FIFO and word_cnt increments.
  - If the RX FIFO is full, the word is dropped, rx_overflow pulses and the FIFO contents are unchanged.
  - A pop and a push in the same cycle on a full FIFO is legal: the push succeeds and there is no overflow.
- TX load points:
  - CPHA=0: the frame_start cycle, and the first shift edge after each word_done.
  - CPHA=1: the first leading edge of each word (bit count 0).
- At each load point:
  - If the TX FIFO is non-empty, pop the head into the TX shifter.
  - Otherwise load IDLE_WORD and pulse tx_underrun.
  - spi_miso takes shifter[DATA_W-1] in the same cycle.
  - On all other shift edges, shift left and drive the new MSB.
- CS deassert (synchronised):
  - Clears the shifters and the bit counter; pulses frame_end.
  - A partial word is discarded and not pushed.
  - FIFO contents survive; word_cnt is cleared on the next frame_start.
- TX push: tx_valid & tx_ready writes the FIFO. A write and a shifter load (pop) in the same cycle are both honoured. Pushes are accepted with CS active or inactive.
- Simultaneous frame_end and word_done: word_done is processed first (the word is pushed), then the clear.
- Latency:
  - spi_clk pin to sample: SYNC_STAGES+1 clk_sys cycles.
  - word_done to rx_valid: 1 cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. Frame resumption after reset is not supported; the master must restart with a fresh CS.

Decomposition:
- Package spi_pkg:
  - SPI mode localparams MODE0..MODE3 as {CPOL,CPHA}.
  - Function clog2 for FIFO pointer widths.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Synchronous FIFO with registered head and full/empty flags.
  - Instantiated twice, for RX and TX.

Test Plan:
- Mode 0, DATA_W=8, TX FIFO preloaded with 8'hA5, 8'h3C; master sends 8'h12, 8'h34 in one frame -> MISO reads A5, 3C; RX pops 12, 34; word_cnt=2; no error pulses.
- CPOL=1, CPHA=1, DATA_W=16; master sends 16'hBEEF with the TX FIFO empty -> rx_data=16'hBEEF; MISO returns IDLE_WORD; tx_underrun pulses once.
- RX_DEPTH=4, rx_ready=0; master sends 5 words 01..05 -> FIFO holds 01..04; rx_overflow pulses once (on 05); no further flags.
- CS deasserted after 5 of 8 bits -> no rx_valid; frame_end pulses; next frame of 8'h77 is received correctly as 77.
- TX FIFO full (tx_ready=0), then the first load point pops a word -> tx_ready=1 the next cycle; a same-cycle push is accepted with no loss.
- rst_n asserted mid-word -> all outputs 0 and FIFOs empty; after release, a fresh frame of 8'h5A is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave FIFO block:
// SPI mode encodings and a constant log2 helper.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage and full/empty flags.
// Ports: push/wr_data in, pop/rd_data out, full, empty.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // a pop frees the slot, so push on full is fine then
  assign pop_ok  = pop & ~empty_q;
  assign push_ok = push & (~full_q | pop_ok);
  assign cnt_nxt = cnt + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(DEPTH));
      empty_q <= (cnt_nxt == '0);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave, any mode, with RX/TX FIFOs on clk_sys.
// Ports: spi_* pins, rx_*/tx_* handshakes, busy,
// frame_start/end pulses, rx_overflow, tx_underrun,
// word_cnt.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter int                RX_DEPTH    = 4,
  parameter int                TX_DEPTH    = 4,
  parameter int                SYNC_STAGES = 3,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '0
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_end,
  output logic              rx_overflow,
  output logic              tx_underrun,
  output logic [15:0]       word_cnt
);

  localparam logic [1:0] MODE = {CPOL, CPHA};
  localparam int         BW   = clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam int         NS   = SYNC_STAGES;

  logic [NS-1:0]     clk_sync;
  logic [NS-1:0]     cs_sync;
  logic [NS-1:0]     mosi_sync;
  logic              clk_d;
  logic              busy_q;
  logic              init_q;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              miso_q;
  logic              load_pend;
  logic [15:0]       wcnt_q;

  logic              clk_now;
  logic              mosi_s;
  logic              cs_act;
  logic              lead;
  logic              trail;
  logic              sample_e;
  logic              shift_e;
  logic              word_done;
  logic              load_pt;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] load_word;

  logic              rx_full;
  logic              rx_empty;
  logic              rx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic [DATA_W-1:0] tx_head;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= {NS{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_d     <= CPOL;
      busy_q    <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[NS-2:0], spi_clk};
      cs_sync   <= {cs_sync[NS-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[NS-2:0], spi_mosi};
      clk_d     <= clk_sync[NS-1];
      busy_q    <= ~cs_sync[NS-1];
      init_q    <= 1'b1;
    end
  end

  assign clk_now = clk_sync[NS-1];
  assign mosi_s  = mosi_sync[NS-1];
  assign cs_act  = ~cs_sync[NS-1];
  assign lead    = (clk_now != CPOL) && (clk_d == CPOL);
  assign trail   = (clk_now == CPOL) && (clk_d != CPOL);

  assign frame_start = cs_act & ~busy_q;
  assign frame_end   = ~cs_act & busy_q;

  // gating on busy_q keeps the final edge alive
  // in the frame_end cycle, so that word lands first
  always_comb begin
    sample_e = 1'b0;
    shift_e  = 1'b0;
    unique case (MODE)
      MODE0, MODE2: begin
        sample_e = busy_q & lead;
        shift_e  = busy_q & trail;
      end
      MODE1, MODE3: begin
        sample_e = busy_q & trail;
        shift_e  = busy_q & lead;
      end
    endcase
  end

  assign word_done = sample_e && (bit_cnt == LAST);
  assign rx_word   = {rx_sh[DATA_W-2:0], mosi_s};

  assign load_pt = CPHA
    ? (shift_e && (bit_cnt == '0))
    : (frame_start | (shift_e & load_pend));

  assign tx_pop      = load_pt & ~tx_empty;
  assign tx_underrun = load_pt & tx_empty;
  assign load_word   = tx_empty ? IDLE_WORD : tx_head;

  assign rx_pop      = rx_valid & rx_ready;
  assign rx_overflow = word_done & rx_full & ~rx_pop;
  assign rx_valid    = ~rx_empty;

  assign tx_ready = ~tx_full & init_q;
  assign tx_push  = tx_valid & tx_ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      miso_q    <= 1'b0;
      load_pend <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      if (sample_e) begin
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        rx_sh   <= rx_word;
      end
      if (word_done)
        load_pend <= 1'b1;
      else if (shift_e)
        load_pend <= 1'b0;
      if (load_pt) begin
        tx_sh  <= load_word;
        miso_q <= load_word[DATA_W-1];
      end else if (shift_e) begin
        tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
        miso_q <= tx_sh[DATA_W-2];
      end
      if (frame_start)
        wcnt_q <= '0;
      else if (word_done && (wcnt_q != 16'hFFFF))
        wcnt_q <= wcnt_q + 16'd1;
      // CS idle wins over everything above
      if (!cs_act) begin
        bit_cnt   <= '0;
        rx_sh     <= '0;
        tx_sh     <= '0;
        miso_q    <= 1'b0;
        load_pend <= 1'b0;
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign busy        = busy_q;
  assign word_cnt    = wcnt_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .push    (word_done),
    .wr_data (rx_word),
    .pop     (rx_pop),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .push    (tx_push),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: mode 0 / 8-bit and
// mode 3 / 16-bit instances against a queue model.
`timescale 1ns/1ps
module tb_spi_slave_fifo;

  localparam int HALF = 200;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_sys = ~clk_sys;

  logic spi_clk  = 1'b0;
  logic spi_mosi = 1'b0;
  logic cs0_n    = 1'b1;
  logic cs3_n    = 1'b1;

  logic        miso0, oe0, rxv0, txr0, busy0;
  logic        fs0, fe0, ovf0, und0;
  logic        rxr0 = 1'b0;
  logic        txv0 = 1'b0;
  logic [7:0]  rxd0;
  logic [7:0]  txd0 = '0;
  logic [15:0] wc0;

  logic        miso3, oe3, rxv3, txr3, busy3;
  logic        fs3, fe3, ovf3, und3;
  logic        rxr3 = 1'b0;
  logic        txv3 = 1'b0;
  logic [15:0] rxd3;
  logic [15:0] txd3 = '0;
  logic [15:0] wc3;

  spi_slave_fifo u0 (
    .clk_sys (clk_sys), .rst_n (rst_n),
    .spi_clk (spi_clk), .spi_mosi (spi_mosi),
    .spi_cs_n (cs0_n), .spi_miso (miso0),
    .spi_miso_oe (oe0), .rx_data (rxd0),
    .rx_valid (rxv0), .rx_ready (rxr0),
    .tx_data (txd0), .tx_valid (txv0),
    .tx_ready (txr0), .busy (busy0),
    .frame_start (fs0), .frame_end (fe0),
    .rx_overflow (ovf0), .tx_underrun (und0),
    .word_cnt (wc0)
  );

  spi_slave_fifo #(
    .DATA_W (16), .CPOL (1'b1), .CPHA (1'b1)
  ) u3 (
    .clk_sys (clk_sys), .rst_n (rst_n),
    .spi_clk (spi_clk), .spi_mosi (spi_mosi),
    .spi_cs_n (cs3_n), .spi_miso (miso3),
    .spi_miso_oe (oe3), .rx_data (rxd3),
    .rx_valid (rxv3), .rx_ready (rxr3),
    .tx_data (txd3), .tx_valid (txv3),
    .tx_ready (txr3), .busy (busy3),
    .frame_start (fs3), .frame_end (fe3),
    .rx_overflow (ovf3), .tx_underrun (und3),
    .word_cnt (wc3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int n_fe0 = 0, n_ovf0 = 0, n_und0 = 0;
  int n_fe3 = 0, n_ovf3 = 0, n_und3 = 0;
  int e_fe0 = 0, e_ovf0 = 0, e_und0 = 0;
  int e_fe3 = 0, e_ovf3 = 0, e_und3 = 0;

  always @(posedge clk_sys) begin
    if (fe0)  n_fe0++;
    if (ovf0) n_ovf0++;
    if (und0) n_und0++;
    if (fe3)  n_fe3++;
    if (ovf3) n_ovf3++;
    if (und3) n_und3++;
  end

  logic [31:0] txm0[$], txm3[$], rxm0[$], rxm3[$];
  logic [31:0] mw[16];
  logic [31:0] mr[16];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    chk("tx_ready_push", 32'(txr0), 1);
    txd0 = d;
    txv0 = 1'b1;
    cyc(1);
    txv0 = 1'b0;
    txm0.push_back(32'(d));
  endtask

  // Drive one frame of nbits; the model derives the
  // expected MISO words, flags and RX contents.
  task automatic frame(input bit sel, input int nbits);
    int w, nfull, loads, wi, bi;
    bit cp;
    logic [31:0] e;
    w  = sel ? 16 : 8;
    cp = sel;
    for (int k = 0; k < 16; k++) mr[k] = '0;
    spi_clk = cp;
    #HALF;
    if (sel) cs3_n = 1'b0;
    else     cs0_n = 1'b0;
    #HALF;
    for (int b = 0; b < nbits; b++) begin
      wi = b / w;
      bi = w - 1 - (b % w);
      if (!sel) begin
        spi_mosi = mw[wi][bi];
        #HALF;
        spi_clk = ~cp;
        mr[wi][bi] = miso0;
        #HALF;
        spi_clk = cp;
      end else begin
        #HALF;
        spi_clk  = ~cp;
        spi_mosi = mw[wi][bi];
        #HALF;
        spi_clk = cp;
        mr[wi][bi] = miso3;
      end
    end
    #HALF;
    if (sel) cs3_n = 1'b1;
    else     cs0_n = 1'b1;
    #(4 * HALF);

    nfull = nbits / w;
    // mode 0 also loads on the shift edge after the
    // last word; mode 3 loads at the start of each word
    loads = sel ? (nbits + w - 1) / w : nfull + 1;
    for (int k = 0; k < loads; k++) begin
      e = '0;
      if (sel && txm3.size() > 0)
        e = txm3.pop_front();
      else if (!sel && txm0.size() > 0)
        e = txm0.pop_front();
      else if (sel)
        e_und3++;
      else
        e_und0++;
      if (k < nfull)
        chk($sformatf("miso%0d_w%0d", sel, k),
            mr[k], e);
    end
    for (int k = 0; k < nfull; k++) begin
      if (sel) begin
        if (rxm3.size() == 4) e_ovf3++;
        else rxm3.push_back(mw[k] & 32'hFFFF);
      end else begin
        if (rxm0.size() == 4) e_ovf0++;
        else rxm0.push_back(mw[k] & 32'hFF);
      end
    end
    if (sel) begin
      e_fe3++;
      chk("word_cnt3", 32'(wc3), nfull);
      chk("underrun3", n_und3, e_und3);
      chk("overflow3", n_ovf3, e_ovf3);
      chk("frame_end3", n_fe3, e_fe3);
    end else begin
      e_fe0++;
      chk("word_cnt0", 32'(wc0), nfull);
      chk("underrun0", n_und0, e_und0);
      chk("overflow0", n_ovf0, e_ovf0);
      chk("frame_end0", n_fe0, e_fe0);
    end
  endtask

  task automatic drain(input bit sel);
    logic [31:0] e;
    if (sel) begin
      while (rxm3.size() > 0) begin
        e = rxm3.pop_front();
        chk("rx_valid3", 32'(rxv3), 1);
        chk("rx_data3", 32'(rxd3), e);
        rxr3 = 1'b1;
        cyc(1);
        rxr3 = 1'b0;
      end
      chk("rx_empty3", 32'(rxv3), 0);
    end else begin
      while (rxm0.size() > 0) begin
        e = rxm0.pop_front();
        chk("rx_valid0", 32'(rxv0), 1);
        chk("rx_data0", 32'(rxd0), e);
        rxr0 = 1'b1;
        cyc(1);
        rxr0 = 1'b0;
      end
      chk("rx_empty0", 32'(rxv0), 0);
    end
  endtask

  initial begin : main
    bit got;
    int np, nw;
    #3;
    chk("rst_tx_ready", 32'(txr0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_oe3", 32'(oe3), 0);
    chk("rst_miso", 32'(miso0), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("init_tx_ready0", 32'(txr0), 1);
    chk("init_tx_ready3", 32'(txr3), 1);
    chk("init_rx_valid0", 32'(rxv0), 0);
    chk("init_rx_data0", 32'(rxd0), 0);
    chk("init_word_cnt0", 32'(wc0), 0);

    // mode 0, two preloaded responses
    push0(8'hA5);
    push0(8'h3C);
    mw[0] = 32'h12;
    mw[1] = 32'h34;
    frame(0, 16);
    drain(0);

    // mode 3, 16-bit, empty TX
    mw[0] = 32'hBEEF;
    frame(1, 16);
    drain(1);

    // RX overflow on the fifth word
    for (int k = 0; k < 5; k++) mw[k] = 32'(k + 1);
    frame(0, 40);
    drain(0);

    // partial word discarded, then a clean word
    mw[0] = 32'hFF;
    frame(0, 5);
    drain(0);
    mw[0] = 32'h77;
    frame(0, 8);
    drain(0);

    // TX full, first load frees a slot for a held push
    for (int k = 0; k < 4; k++)
      push0(8'(8'hA1 + k));
    chk("tx_full", 32'(txr0), 0);
    for (int k = 0; k < 5; k++)
      mw[k] = 32'($urandom_range(0, 255));
    txd0 = 8'hE7;
    txv0 = 1'b1;
    fork
      frame(0, 40);
      begin
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
          cyc(1);
          if (txr0) got = 1'b1;
        end
        chk("tx_ready_after_load", 32'(got), 1);
        cyc(1);
        txv0 = 1'b0;
        if (got) txm0.push_back(32'hE7);
      end
    join
    drain(0);

    // reset in the middle of a word
    push0(8'hC3);
    spi_clk = 1'b0;
    #HALF;
    cs0_n = 1'b0;
    #HALF;
    for (int b = 0; b < 4; b++) begin
      spi_mosi = b[0];
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy0), 0);
    chk("mid_oe", 32'(oe0), 0);
    chk("mid_miso", 32'(miso0), 0);
    chk("mid_rx_valid", 32'(rxv0), 0);
    chk("mid_word_cnt", 32'(wc0), 0);
    chk("mid_flags",
        32'({fs0, fe0, ovf0, und0}), 0);
    chk("mid_tx_ready", 32'(txr0), 0);
    cs0_n = 1'b1;
    txm0.delete();
    rxm0.delete();
    cyc(5);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_tx_ready", 32'(txr0), 1);
    mw[0] = 32'h5A;
    frame(0, 8);
    drain(0);

    // randomised mode 0 frames
    for (int r = 0; r < 4; r++) begin
      np = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      for (int i = 0; i < np; i++)
        push0(8'($urandom_range(0, 255)));
      for (int k = 0; k < nw; k++)
        mw[k] = 32'($urandom_range(0, 255));
      frame(0, nw * 8);
      drain(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
